ex_muldiv: RTL and testbench
============================

# ex_muldiv

Iterative RV32M multiply/divide unit in the execute stage, directly downstream of the ID/EX pipeline register. It takes the forwarded EX operands of an M-extension instruction and computes the result over multiple cycles. While it works, it holds the instruction in EX by asserting a stall, then presents a one-cycle-valid result to the EX result mux.

## Interface
- `XLEN`, default 32: operand/result width. Only 32 is supported.
- `i_clk` input 1: clock. All state changes on the rising edge.
- `i_rst` input 1: synchronous, active-high reset.
- `i_clk_en` input 1: pipeline clock enable. When low, all state is frozen.
- `i_flush` input 1: synchronous abort of the operation in progress (EX flush or exception).
- `i_start` input 1: an M instruction occupies EX. Held high until the pipeline advances.
- `i_funct3` input 3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- `i_op_a` input 32: rs1 value, after forwarding.
- `i_op_b` input 32: rs2 value, after forwarding.
- `o_stall` output 1: hold IF/ID/EX. Defined as `i_start & ~o_done`, combinational.
- `o_busy` output 1: an iteration is in progress.
- `o_done` output 1: `o_result` is valid this cycle.
- `o_result` output 32: the result.

## Operation
- FSM has three states: IDLE, RUN, DONE. All outputs reset to 0. After reset the state is IDLE.
- Priority order: `i_rst` > `i_flush` > `i_clk_en` gating > normal transitions.
- IDLE → RUN when `i_start` is high. At that edge, latch `funct3`, the operand magnitudes, the result sign and a 5-bit counter set to 0.
  - Signed ops (MULH, DIV, REM): both operands are signed.
  - MULHSU: only a is signed.
  - Unsigned ops: no sign handling.
- RUN performs one iteration per enabled edge:
  - Multiply: shift-add into a 64-bit accumulator.
  - Divide: restoring step yielding 32-bit quotient and remainder.
  - When the counter reaches 31, apply the sign fix-up and go to DONE.
- DONE drives `o_done`=1 and the selected result:
  - MUL: low 32 bits.
  - MULH/MULHSU/MULHU: high 32 bits.
  - DIV/DIVU: quotient.
  - REM/REMU: remainder.
- DONE → IDLE on the next enabled edge. `o_result` holds its value until the next completion.
- Sign rules:
  - Product is negated if the operand signs differ (signed ops only).
  - Quotient is negated if signs differ.
  - Remainder takes the sign of the dividend.
- Special cases skip RUN (IDLE → DONE at the accepting edge):
  - Divide by zero: quotient = 0xFFFFFFFF, remainder = `op_a`.
  - Signed overflow (0x80000000 / 0xFFFFFFFF): quotient = 0x80000000, remainder = 0.
- Operand changes during RUN are ignored because operands are latched.
- `i_start` low in RUN (e.g. an external flush without `i_flush`): the computation finishes anyway and the result is discarded.
- `i_flush` in any state → IDLE with `o_busy`=0 and `o_done`=0. A simultaneous `i_start` is ignored.

## Timing
- Accepting edge is E.
- Iterative path: `o_busy`=1 from E through the edge E+32. `o_done`=1 in the cycle after E+32, i.e. 33 cycles of stall counting the first cycle.
- Special-case or fast path: `o_done`=1 in the cycle after E, i.e. 1 stall cycle.
- `o_stall` drops in the same cycle `o_done` rises, so the pipeline advances on that edge.
- With `i_clk_en` low, every edge is skipped. Latency in enabled edges is unchanged, and DONE persists until an enabled edge.
- Back-to-back M instructions: a new start is accepted on the edge after DONE, because the state must pass through IDLE (one bubble).

## Configuration
- `EX_MULDIV_FAST_MUL_EN` defined: MUL/MULH* use a single-cycle 33×33 signed multiplier, IDLE → DONE at E. Divide stays iterative.
- Not defined: all multiplies use the 32-iteration shift-add path.

## Structure
- `muldiv_pkg` holds:
  - The funct3 localparams (MUL…REMU).
  - The FSM state encoding.
  - The constants `DIV0_QUOT` (0xFFFFFFFF) and `INT_MIN` (0x80000000).
- One sub-module, `ex_div_step`: a combinational restoring-division step. Inputs are the partial remainder, the quotient and the divisor; outputs are the next partial remainder and the next quotient.

## Test plan
- MUL 7 × −3, start at E → `o_stall` for 33 cycles, `o_done` at E+33 with `o_result`=0xFFFFFFEB. With the macro: `o_done` at E+1.
- MULHU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFE. MULH 0x80000000 × 0x80000000 → 0x40000000.
- DIV −7 / 2 → 0xFFFFFFFD. REM −7 / 2 → 0xFFFFFFFF. DIVU 100 / 7 → 14. REMU 100 / 7 → 2.
- DIV 5 / 0 → 0xFFFFFFFF, `o_done` at E+1. REM 5 / 0 → 5. DIV 0x80000000 / −1 → 0x80000000. REM of the same → 0.
- `i_flush` at E+10 during DIV → IDLE next cycle, `o_busy` and `o_done` stay 0. A new DIVU 9 / 3 started afterwards → 3.
- `i_clk_en` low for 5 cycles mid-RUN and for 2 cycles in DONE → `o_done` delayed exactly 5 cycles and held 3 cycles, with the result unchanged. `i_rst` mid-RUN → all outputs 0 on the next cycle.

Source files
------------

// File: rtl/muldiv_pkg.sv
// Shared definitions for the RV32M iterative multiply/divide unit.
package muldiv_pkg;

    // funct3 encodings of the M-extension instructions
    localparam logic [2:0] MUL    = 3'b000;
    localparam logic [2:0] MULH   = 3'b001;
    localparam logic [2:0] MULHSU = 3'b010;
    localparam logic [2:0] MULHU  = 3'b011;
    localparam logic [2:0] DIV    = 3'b100;
    localparam logic [2:0] DIVU   = 3'b101;
    localparam logic [2:0] REM    = 3'b110;
    localparam logic [2:0] REMU   = 3'b111;

    // Iteration counter width (32 iterations)
    localparam int unsigned CNT_W = 5;

    // Architectural special-case results
    localparam logic [31:0] DIV0_QUOT = 32'hFFFF_FFFF;
    localparam logic [31:0] INT_MIN   = 32'h8000_0000;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

endpackage

// File: rtl/ex_div_step.sv
// One combinational restoring-division step on unsigned magnitudes.
module ex_div_step #(
    parameter int unsigned W = 32
) (
    input  logic [W-1:0] i_rem,
    input  logic [W-1:0] i_quo,
    input  logic [W-1:0] i_div,
    output logic [W-1:0] o_rem,
    output logic [W-1:0] o_quo
);

    logic [W:0] w_shift;
    logic [W:0] w_diff;
    logic       w_ge;

    // Shift in the next dividend bit and trial-subtract the divisor
    always_comb begin
        w_shift = {i_rem, i_quo[W-1]};
        w_diff  = w_shift - {1'b0, i_div};
        w_ge    = ~w_diff[W];
        o_rem   = w_ge ? w_diff[W-1:0] : w_shift[W-1:0];
        o_quo   = {i_quo[W-2:0], w_ge};
    end

endmodule

// File: rtl/ex_muldiv.sv
// RV32M multiply/divide unit for the EX stage. Iterative shift-add multiply
// and restoring divide, 32 iterations each; holds EX via o_stall.
// Optional: EX_MULDIV_FAST_MUL_EN selects a single-cycle multiplier for
// MUL/MULH/MULHSU/MULHU; divide stays iterative.
module ex_muldiv
    import muldiv_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_clk_en,
    input  logic            i_flush,
    input  logic            i_start,
    input  logic [2:0]      i_funct3,
    input  logic [XLEN-1:0] i_op_a,
    input  logic [XLEN-1:0] i_op_b,
    output logic            o_stall,
    output logic            o_busy,
    output logic            o_done,
    output logic [XLEN-1:0] o_result
);

    state_e              r_state;
    state_e              w_state_nxt;
    logic [2:0]          r_fn;
    logic [XLEN-1:0]     r_opnd;
    logic [2*XLEN-1:0]   r_acc;
    logic                r_neg_res;
    logic                r_neg_rem;
    logic [CNT_W-1:0]    r_cnt;
    logic                r_busy;
    logic                r_done;
    logic [XLEN-1:0]     r_result;
    logic                w_busy_nxt;
    logic                w_done_nxt;

    logic                w_is_div;
    logic                w_a_sgn;
    logic                w_b_sgn;
    logic [XLEN-1:0]     w_a_mag;
    logic [XLEN-1:0]     w_b_mag;
    logic                w_div0;
    logic                w_ovf;
    logic [XLEN-1:0]     w_spec_res;
    logic                w_short;
    logic [XLEN-1:0]     w_short_res;

    logic [XLEN:0]       w_mul_sum;
    logic [XLEN-1:0]     w_div_rem;
    logic [XLEN-1:0]     w_div_quo;
    logic [2*XLEN-1:0]   w_acc_step;
    logic [2*XLEN-1:0]   w_prod;
    logic [XLEN-1:0]     w_quo_fix;
    logic [XLEN-1:0]     w_rem_fix;
    logic [XLEN-1:0]     w_fix_res;

    // Operand decode: signedness, magnitudes and the cases that skip iteration
    always_comb begin
        w_is_div   = i_funct3[2];
        w_a_sgn    = i_op_a[XLEN-1] & ((i_funct3 == MULH) | (i_funct3 == MULHSU) |
                                       (i_funct3 == DIV)  | (i_funct3 == REM));
        w_b_sgn    = i_op_b[XLEN-1] & ((i_funct3 == MULH) | (i_funct3 == DIV) |
                                       (i_funct3 == REM));
        w_a_mag    = w_a_sgn ? (~i_op_a + XLEN'(1)) : i_op_a;
        w_b_mag    = w_b_sgn ? (~i_op_b + XLEN'(1)) : i_op_b;
        w_div0     = w_is_div & (i_op_b == '0);
        w_ovf      = ((i_funct3 == DIV) | (i_funct3 == REM)) &
                     (i_op_a == INT_MIN) & (i_op_b == DIV0_QUOT);
        w_spec_res = '0;
        if (w_div0) begin
            w_spec_res = i_funct3[1] ? i_op_a : DIV0_QUOT;
        end else if (w_ovf) begin
            w_spec_res = i_funct3[1] ? '0 : INT_MIN;
        end
    end

`ifdef EX_MULDIV_FAST_MUL_EN
    logic signed [XLEN:0]     w_fa;
    logic signed [XLEN:0]     w_fb;
    logic signed [2*XLEN-1:0] w_fa_x;
    logic signed [2*XLEN-1:0] w_fb_x;
    logic signed [2*XLEN-1:0] w_fp;

    // Single-cycle 33x33 signed product; the extra bit carries operand sign
    always_comb begin
        w_fa        = $signed({w_a_sgn, i_op_a});
        w_fb        = $signed({w_b_sgn, i_op_b});
        w_fa_x      = (2*XLEN)'(w_fa);
        w_fb_x      = (2*XLEN)'(w_fb);
        w_fp        = w_fa_x * w_fb_x;
        w_short     = w_div0 | w_ovf | ~w_is_div;
        w_short_res = (w_div0 | w_ovf) ? w_spec_res :
                      (i_funct3 == MUL) ? w_fp[XLEN-1:0] : w_fp[2*XLEN-1:XLEN];
    end
`else
    // Only the divide special cases complete without iterating
    always_comb begin
        w_short     = w_div0 | w_ovf;
        w_short_res = w_spec_res;
    end
`endif

    ex_div_step #(.W(XLEN)) u_div_step (
        .i_rem (r_acc[2*XLEN-1:XLEN]),
        .i_quo (r_acc[XLEN-1:0]),
        .i_div (r_opnd),
        .o_rem (w_div_rem),
        .o_quo (w_div_quo)
    );

    // One iteration of the datapath plus sign fix-up of the final value
    always_comb begin
        w_mul_sum  = {1'b0, r_acc[2*XLEN-1:XLEN]} + (r_acc[0] ? {1'b0, r_opnd} : '0);
        w_acc_step = r_fn[2] ? {w_div_rem, w_div_quo} : {w_mul_sum, r_acc[XLEN-1:1]};
        w_prod     = r_neg_res ? (~w_acc_step + (2*XLEN)'(1)) : w_acc_step;
        w_quo_fix  = r_neg_res ? (~w_div_quo + XLEN'(1)) : w_div_quo;
        w_rem_fix  = r_neg_rem ? (~w_div_rem + XLEN'(1)) : w_div_rem;
        case (r_fn)
            MUL:                 w_fix_res = w_prod[XLEN-1:0];
            MULH, MULHSU, MULHU: w_fix_res = w_prod[2*XLEN-1:XLEN];
            DIV, DIVU:           w_fix_res = w_quo_fix;
            default:             w_fix_res = w_rem_fix;
        endcase
    end

    // FSM state register
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= ST_IDLE;
        end else if (i_flush) begin
            r_state <= ST_IDLE;
        end else if (i_clk_en) begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (i_start) begin
                    w_state_nxt = w_short ? ST_DONE : ST_RUN;
                end
            end
            ST_RUN: begin
                if (r_cnt == CNT_W'(31)) begin
                    w_state_nxt = ST_DONE;
                end
            end
            ST_DONE: w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // FSM output logic: status flags follow the state being entered
    always_comb begin
        w_busy_nxt = (w_state_nxt == ST_RUN);
        w_done_nxt = (w_state_nxt == ST_DONE);
    end

    // Registered status flags
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_busy <= 1'b0;
            r_done <= 1'b0;
        end else if (i_flush) begin
            r_busy <= 1'b0;
            r_done <= 1'b0;
        end else if (i_clk_en) begin
            r_busy <= w_busy_nxt;
            r_done <= w_done_nxt;
        end
    end

    // Operand latch, iteration and result capture
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_fn      <= '0;
            r_opnd    <= '0;
            r_acc     <= '0;
            r_neg_res <= 1'b0;
            r_neg_rem <= 1'b0;
            r_cnt     <= '0;
            r_result  <= '0;
        end else if (!i_flush && i_clk_en) begin
            case (r_state)
                ST_IDLE: begin
                    if (i_start) begin
                        r_fn      <= i_funct3;
                        r_cnt     <= '0;
                        r_neg_res <= w_a_sgn ^ w_b_sgn;
                        r_neg_rem <= w_a_sgn;
                        if (w_is_div) begin
                            r_acc  <= {{XLEN{1'b0}}, w_a_mag};
                            r_opnd <= w_b_mag;
                        end else begin
                            r_acc  <= {{XLEN{1'b0}}, w_b_mag};
                            r_opnd <= w_a_mag;
                        end
                        if (w_short) begin
                            r_result <= w_short_res;
                        end
                    end
                end
                ST_RUN: begin
                    r_acc <= w_acc_step;
                    r_cnt <= r_cnt + CNT_W'(1);
                    if (r_cnt == CNT_W'(31)) begin
                        r_result <= w_fix_res;
                    end
                end
                default: ;
            endcase
        end
    end

    assign o_stall  = i_start & ~r_done;
    assign o_busy   = r_busy;
    assign o_done   = r_done;
    assign o_result = r_result;

endmodule

// File: tb/tb_ex_muldiv.sv
// Directed self-checking bench for ex_muldiv.
module tb_ex_muldiv;

`ifdef EX_MULDIV_FAST_MUL_EN
    localparam int MUL_LAT = 1;
`else
    localparam int MUL_LAT = 33;
`endif

    logic        i_clk = 1'b0;
    logic        i_rst;
    logic        i_clk_en;
    logic        i_flush;
    logic        i_start;
    logic [2:0]  i_funct3;
    logic [31:0] i_op_a;
    logic [31:0] i_op_b;
    logic        o_stall;
    logic        o_busy;
    logic        o_done;
    logic [31:0] o_result;

    int n_chk  = 0;
    int n_fail = 0;

    ex_muldiv #(.XLEN(32)) dut (
        .i_clk    (i_clk),
        .i_rst    (i_rst),
        .i_clk_en (i_clk_en),
        .i_flush  (i_flush),
        .i_start  (i_start),
        .i_funct3 (i_funct3),
        .i_op_a   (i_op_a),
        .i_op_b   (i_op_b),
        .o_stall  (o_stall),
        .o_busy   (o_busy),
        .o_done   (o_done),
        .o_result (o_result)
    );

    always #5 i_clk = ~i_clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Issue one M instruction and check latency, stall length and result
    task automatic run_op(input string tag, input logic [2:0] f, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp, input int exp_lat);
        int cyc    = 0;
        int stalls = 0;
        bit seen   = 0;
        @(negedge i_clk);
        i_start  = 1'b1;
        i_funct3 = f;
        i_op_a   = a;
        i_op_b   = b;
        #1;
        if (o_stall) stalls++;
        while (!seen && cyc < 100) begin
            @(negedge i_clk);
            cyc++;
            if (cyc == 1) begin
                i_op_a = 32'hDEAD_BEEF;
                i_op_b = 32'h1234_5678;
            end
            if (o_done) seen = 1;
            else if (o_stall) stalls++;
        end
        check({tag, "_lat"}, 32'(cyc), 32'(exp_lat));
        check({tag, "_stall_cycles"}, 32'(stalls), 32'(exp_lat));
        check({tag, "_res"}, o_result, exp);
        check({tag, "_stall_at_done"}, {31'd0, o_stall}, 32'd0);
        i_start = 1'b0;
        @(negedge i_clk);
        check({tag, "_done_clr"}, {31'd0, o_done}, 32'd0);
        check({tag, "_hold"}, o_result, exp);
    endtask

    initial begin
        int first_done;
        int done_cnt;
        i_rst = 1'b1; i_clk_en = 1'b1; i_flush = 1'b0; i_start = 1'b0;
        i_funct3 = 3'd0; i_op_a = '0; i_op_b = '0;
        repeat (3) @(negedge i_clk);
        i_rst = 1'b0;
        @(negedge i_clk);
        check("rst_busy",   {31'd0, o_busy},  32'd0);
        check("rst_done",   {31'd0, o_done},  32'd0);
        check("rst_stall",  {31'd0, o_stall}, 32'd0);
        check("rst_result", o_result,         32'd0);

        run_op("mul",      3'b000, 32'd7,        32'hFFFF_FFFD, 32'hFFFF_FFEB, MUL_LAT);
        run_op("mulhu",    3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, MUL_LAT);
        run_op("mulh",     3'b001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, MUL_LAT);
        run_op("mulhsu",   3'b010, 32'hFFFF_FFFF, 32'd2,        32'hFFFF_FFFF, MUL_LAT);
        run_op("div",      3'b100, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFD, 33);
        run_op("rem",      3'b110, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, 33);
        run_op("div_nb",   3'b100, 32'd7,        32'hFFFF_FFFE, 32'hFFFF_FFFD, 33);
        run_op("rem_nb",   3'b110, 32'd7,        32'hFFFF_FFFE, 32'd1,        33);
        run_op("divu",     3'b101, 32'd100,      32'd7,        32'd14,       33);
        run_op("remu",     3'b111, 32'd100,      32'd7,        32'd2,        33);
        run_op("div0",     3'b100, 32'd5,        32'd0,        32'hFFFF_FFFF, 1);
        run_op("rem0",     3'b110, 32'd5,        32'd0,        32'd5,        1);
        run_op("divu0",    3'b101, 32'd7,        32'd0,        32'hFFFF_FFFF, 1);
        run_op("remu0",    3'b111, 32'd7,        32'd0,        32'd7,        1);
        run_op("div_ovf",  3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
        run_op("rem_ovf",  3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,        1);

        // Flush during a divide: seen at edge E+10
        @(negedge i_clk);
        i_start = 1'b1; i_funct3 = 3'b100; i_op_a = 32'd1000; i_op_b = 32'd3;
        repeat (10) @(negedge i_clk);
        check("flush_busy_before", {31'd0, o_busy}, 32'd1);
        i_flush = 1'b1;
        @(negedge i_clk);
        check("flush_busy", {31'd0, o_busy}, 32'd0);
        check("flush_done", {31'd0, o_done}, 32'd0);
        i_flush = 1'b0; i_start = 1'b0;
        done_cnt = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge i_clk);
            if (o_done || o_busy) done_cnt++;
        end
        check("flush_quiet", 32'(done_cnt), 32'd0);
        run_op("divu_after_flush", 3'b101, 32'd9, 32'd3, 32'd3, 33);

        // Clock-enable low 5 cycles mid-RUN and 2 cycles in DONE
        @(negedge i_clk);
        i_start = 1'b1; i_funct3 = 3'b101; i_op_a = 32'd100; i_op_b = 32'd7;
        first_done = 0;
        done_cnt   = 0;
        for (int c = 1; c <= 60; c++) begin
            @(negedge i_clk);
            if (o_done) begin
                done_cnt++;
                if (first_done == 0) first_done = c;
                check("clken_res", o_result, 32'd14);
                i_start = 1'b0;
            end
            i_clk_en = !((c >= 10 && c < 15) || c == 38 || c == 39);
        end
        i_clk_en = 1'b1;
        check("clken_first_done", 32'(first_done), 32'd38);
        check("clken_done_len",   32'(done_cnt),   32'd3);

        // Reset in the middle of an iterative operation
        @(negedge i_clk);
        i_start = 1'b1; i_funct3 = 3'b101; i_op_a = 32'd50; i_op_b = 32'd5;
        repeat (5) @(negedge i_clk);
        check("pre_rst_busy", {31'd0, o_busy}, 32'd1);
        i_rst = 1'b1; i_start = 1'b0;
        @(negedge i_clk);
        check("midrst_busy",   {31'd0, o_busy},  32'd0);
        check("midrst_done",   {31'd0, o_done},  32'd0);
        check("midrst_stall",  {31'd0, o_stall}, 32'd0);
        check("midrst_result", o_result,         32'd0);
        i_rst = 1'b0;
        run_op("mul_after_rst", 3'b000, 32'd6, 32'd7, 32'd42, MUL_LAT);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
